// File: rtl/credit_bp_rx_nvc.sv
// Credit-based NoC receiver: VC_W per-VC FIFOs, per-VC valid/backpressure heads, sticky errors.
// Optional macro CREDIT_BP_RX_NVC_REG_CREDIT_EN registers the credit return one cycle after the pop.
module credit_bp_rx_nvc #(
  parameter int VC_W  = 2,
  parameter int D_W   = 32,
  parameter int A_W   = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PW    = A_W + D_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VC_W-1:0]       i_vc_target,
  input  logic [PW-1:0]         i_packet,
  output logic [VC_W-1:0]       o_vc_credit_gnt,
  output logic [VC_W-1:0]       o_v,
  output logic [VC_W*PW-1:0]    o_d,
  input  logic [VC_W-1:0]       i_b,
  output logic [VC_W*CNT_W-1:0] o_count,
  output logic [VC_W-1:0]       o_err,
  input  logic                  i_err_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a flit pops from VC v on every edge where o_v[v]=1 and i_b[v]=0;
  // the head is held stable while i_b[v]=1. One credit is returned per pop.
  logic [VC_W-1:0] pop;
  logic [VC_W-1:0] err_set;
  logic            multi_hot;
  logic            one_hot;

  assign pop       = o_v & ~i_b;
  assign multi_hot = (i_vc_target & (i_vc_target - VC_W'(1))) != '0;
  assign one_hot   = (i_vc_target != '0) && !multi_hot;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar v = 0; v < VC_W; v++) begin : g_vc
    logic [PW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;

    assign full = (count == CNT_W'(DEPTH));
    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign push       = one_hot & i_vc_target[v] & (~full | pop[v]);
    assign err_set[v] = i_vc_target[v] & (multi_hot | (full & ~pop[v]));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= i_packet;
          wr_ptr      <= ptr_next(wr_ptr);
        end
        if (pop[v]) rd_ptr <= ptr_next(rd_ptr);
        case ({push, pop[v]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    assign o_v[v]                     = (count != '0);
    assign o_d[v*PW +: PW]            = mem[rd_ptr];
    assign o_count[v*CNT_W +: CNT_W]  = count;
  end

  // A newly detected error overrides a same-edge clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_err <= '0;
    end else if (i_err_clr) begin
      o_err <= err_set;
    end else begin
      o_err <= o_err | err_set;
    end
  end

`ifdef CREDIT_BP_RX_NVC_REG_CREDIT_EN
  logic [VC_W-1:0] gnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) gnt_q <= '0;
    else        gnt_q <= pop;
  end
  assign o_vc_credit_gnt = gnt_q;
`else
  assign o_vc_credit_gnt = pop;
`endif

endmodule

// File: tb/tb_credit_bp_rx_nvc.sv
// Scoreboard bench for credit_bp_rx_nvc: directed scenarios plus a random back-to-back run.
module tb_credit_bp_rx_nvc;
  localparam int VC_W  = 2;
  localparam int D_W   = 32;
  localparam int A_W   = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int PW    = A_W + D_W + 1;
`ifdef CREDIT_BP_RX_NVC_REG_CREDIT_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [VC_W-1:0]       i_vc_target;
  logic [PW-1:0]         i_packet;
  logic [VC_W-1:0]       o_vc_credit_gnt;
  logic [VC_W-1:0]       o_v;
  logic [VC_W*PW-1:0]    o_d;
  logic [VC_W-1:0]       i_b;
  logic [VC_W*CNT_W-1:0] o_count;
  logic [VC_W-1:0]       o_err;
  logic                  i_err_clr;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];

  credit_bp_rx_nvc #(.VC_W(VC_W), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_vc_target(i_vc_target), .i_packet(i_packet),
    .o_vc_credit_gnt(o_vc_credit_gnt), .o_v(o_v), .o_d(o_d), .i_b(i_b),
    .o_count(o_count), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] head(input int v);
    return o_d[v*PW +: PW];
  endfunction

  function automatic logic [CNT_W-1:0] cnt(input int v);
    return o_count[v*CNT_W +: CNT_W];
  endfunction

  function automatic logic [PW-1:0] flit_of(input int unsigned x);
    logic [31:0] d;
    d = x;
    return {d[0], d[7:0], d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int v, input logic [PW-1:0] d);
    if (v == 0) exp_q0.push_back(d);
    else        exp_q1.push_back(d);
  endtask

  task automatic sb_pop(input int v, output logic [PW-1:0] d, output bit ok);
    ok = 1'b1;
    d  = '0;
    if (v == 0) begin
      if (exp_q0.size() == 0) ok = 1'b0;
      else d = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) ok = 1'b0;
      else d = exp_q1.pop_front();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_vc_target = '0; i_packet = '0; i_b = '0; i_err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (o_v !== 2'b00) begin bad++; $display("FAIL reset_v got=%b want=00", o_v); end
    total++; if (o_count !== '0) begin bad++; $display("FAIL reset_count got=%h want=0", o_count); end
    total++; if (o_err !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", o_err); end
    total++; if (o_vc_credit_gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", o_vc_credit_gnt); end
    total++; if ($isunknown(o_d)) begin bad++; $display("FAIL reset_d_known got=%h want=no X", o_d); end
    tick; tick;
    total++; if (o_v !== 2'b00 || o_count !== '0 || o_err !== 2'b00 || o_vc_credit_gnt !== 2'b00) begin
      bad++; $display("FAIL idle_hold got v=%b cnt=%h err=%b gnt=%b want all zero", o_v, o_count, o_err, o_vc_credit_gnt);
    end
  endtask

  task automatic test_single;
    logic [PW-1:0] f, e;
    bit ok;
    i_b = 2'b10;
    f = {1'b1, 8'h5A, 32'hDEADBEEF};
    i_packet = f; i_vc_target = 2'b01; sb_push(0, f);
    tick;
    i_vc_target = '0;
    total++; if (o_v !== 2'b01) begin bad++; $display("FAIL single_v got=%b want=01", o_v); end
    total++; if (head(0)[D_W-1:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h want=deadbeef", head(0)[D_W-1:0]); end
    sb_pop(0, e, ok);
    total++; if (!ok || head(0) !== e) begin bad++; $display("FAIL single_flit got=%h want=%h", head(0), e); end
    total++; if (cnt(0) !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", cnt(0)); end
    total++; if (o_vc_credit_gnt !== (REG ? 2'b00 : 2'b01)) begin
      bad++; $display("FAIL single_gnt_pop got=%b want=%b", o_vc_credit_gnt, REG ? 2'b00 : 2'b01);
    end
    tick;
    total++; if (o_v !== 2'b00 || cnt(0) !== 3'd0) begin bad++; $display("FAIL single_empty got v=%b cnt=%0d want 00/0", o_v, cnt(0)); end
    total++; if (o_vc_credit_gnt !== (REG ? 2'b01 : 2'b00)) begin
      bad++; $display("FAIL single_gnt_after got=%b want=%b", o_vc_credit_gnt, REG ? 2'b01 : 2'b00);
    end
    tick;
    total++; if (o_vc_credit_gnt !== 2'b00) begin bad++; $display("FAIL single_gnt_idle got=%b want=00", o_vc_credit_gnt); end
  endtask

  task automatic test_fill_drain;
    logic [PW-1:0] f, e;
    bit ok;
    i_b = 2'b11;
    for (int ii = 0; ii < DEPTH; ii++) begin
      f = flit_of(ii * 456);
      i_packet = f; i_vc_target = 2'b10; sb_push(1, f);
      tick;
    end
    i_vc_target = '0;
    total++; if (cnt(1) !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", cnt(1)); end
    total++; if (o_vc_credit_gnt !== 2'b00) begin bad++; $display("FAIL fill_gnt got=%b want=00", o_vc_credit_gnt); end
    i_packet = flit_of(999); i_vc_target = 2'b10;
    tick;
    i_vc_target = '0;
    total++; if (o_err !== 2'b10) begin bad++; $display("FAIL overflow_err got=%b want=10", o_err); end
    total++; if (cnt(1) !== 3'd4) begin bad++; $display("FAIL overflow_count got=%0d want=4", cnt(1)); end
    i_err_clr = 1'b1;
    tick;
    i_err_clr = 1'b0;
    total++; if (o_err !== 2'b00) begin bad++; $display("FAIL overflow_clr got=%b want=00", o_err); end
    i_b = 2'b00;
    #1;
    for (int ii = 0; ii < DEPTH; ii++) begin
      total++; if (o_v[1] !== 1'b1) begin bad++; $display("FAIL drain_v[%0d] got=%b want=1", ii, o_v[1]); end
      sb_pop(1, e, ok);
      total++; if (!ok || head(1) !== e) begin bad++; $display("FAIL drain_flit[%0d] got=%h want=%h", ii, head(1), e); end
      total++; if (o_vc_credit_gnt[1] !== (REG ? (ii > 0) : 1'b1)) begin
        bad++; $display("FAIL drain_gnt[%0d] got=%b want=%b", ii, o_vc_credit_gnt[1], REG ? (ii > 0) : 1'b1);
      end
      tick;
    end
    total++; if (o_v !== 2'b00 || cnt(1) !== 3'd0) begin bad++; $display("FAIL drain_empty got v=%b cnt=%0d want 00/0", o_v, cnt(1)); end
    total++; if (o_vc_credit_gnt !== (REG ? 2'b10 : 2'b00)) begin
      bad++; $display("FAIL drain_gnt_end got=%b want=%b", o_vc_credit_gnt, REG ? 2'b10 : 2'b00);
    end
    tick;
  endtask

  task automatic test_full_same_edge;
    logic [PW-1:0] f, e;
    bit ok;
    i_b = 2'b11;
    for (int ii = 0; ii < DEPTH; ii++) begin
      f = flit_of(ii * 77 + 5);
      i_packet = f; i_vc_target = 2'b10; sb_push(1, f);
      tick;
    end
    f = {1'b0, 8'h22, 32'h22222222};
    i_packet = f; i_vc_target = 2'b10; i_b = 2'b00;
    #1;
    sb_pop(1, e, ok);
    total++; if (!ok || head(1) !== e) begin bad++; $display("FAIL same_edge_head got=%h want=%h", head(1), e); end
    sb_push(1, f);
    tick;
    i_vc_target = '0; i_b = 2'b11;
    total++; if (cnt(1) !== 3'd4) begin bad++; $display("FAIL same_edge_count got=%0d want=4", cnt(1)); end
    total++; if (o_err !== 2'b00) begin bad++; $display("FAIL same_edge_err got=%b want=00", o_err); end
    i_b = 2'b00;
    #1;
    for (int ii = 0; ii < DEPTH; ii++) begin
      sb_pop(1, e, ok);
      total++; if (!ok || head(1) !== e) begin bad++; $display("FAIL same_edge_drain[%0d] got=%h want=%h", ii, head(1), e); end
      tick;
    end
    total++; if (o_v !== 2'b00 || exp_q1.size() != 0) begin
      bad++; $display("FAIL same_edge_end got v=%b left=%0d want 00/0", o_v, exp_q1.size());
    end
    tick;
  endtask

  task automatic test_multi_hot_reset;
    logic [PW-1:0] f;
    i_b = 2'b11;
    f = flit_of(32'h1111);
    i_packet = f; i_vc_target = 2'b01; sb_push(0, f);
    tick;
    i_packet = flit_of(123); i_vc_target = 2'b11; i_err_clr = 1'b1;
    tick;
    i_vc_target = '0; i_err_clr = 1'b0;
    total++; if (o_err !== 2'b11) begin bad++; $display("FAIL multi_err got=%b want=11", o_err); end
    total++; if (o_v !== 2'b01 || cnt(0) !== 3'd1 || cnt(1) !== 3'd0) begin
      bad++; $display("FAIL multi_nowrite got v=%b c0=%0d c1=%0d want 01/1/0", o_v, cnt(0), cnt(1));
    end
    i_err_clr = 1'b1;
    tick;
    i_err_clr = 1'b0;
    total++; if (o_err !== 2'b00) begin bad++; $display("FAIL multi_clr got=%b want=00", o_err); end
    for (int ii = 0; ii < 2; ii++) begin
      f = flit_of(32'h2000 + ii);
      i_packet = f; i_vc_target = 2'b01; sb_push(0, f);
      tick;
    end
    i_vc_target = '0;
    total++; if (cnt(0) !== 3'd3) begin bad++; $display("FAIL pre_reset_count got=%0d want=3", cnt(0)); end
    rst_n = 1'b0;
    tick;
    total++; if (o_v !== 2'b00 || o_count !== '0 || o_err !== 2'b00 || o_vc_credit_gnt !== 2'b00) begin
      bad++; $display("FAIL mid_reset got v=%b cnt=%h err=%b gnt=%b want all zero", o_v, o_count, o_err, o_vc_credit_gnt);
    end
    rst_n = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    i_b = 2'b00;
    tick;
    total++; if (o_v !== 2'b00) begin bad++; $display("FAIL post_reset_v got=%b want=00", o_v); end
  endtask

  task automatic test_back_to_back;
    int mc [VC_W];
    logic [VC_W-1:0] pop_m, prev_pop, tgt;
    logic [PW-1:0] f, e;
    bit ok;
    int r, guard;
    mc[0] = 0; mc[1] = 0; prev_pop = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int v = 0; v < VC_W; v++) begin
        total++; if (cnt(v) !== CNT_W'(mc[v]) || o_v[v] !== (mc[v] != 0)) begin
          bad++; $display("FAIL b2b_count[%0d] vc%0d got cnt=%0d v=%b want cnt=%0d", cyc, v, cnt(v), o_v[v], mc[v]);
        end
      end
      i_b = 2'($urandom_range(0, 3));
      #1;
      for (int v = 0; v < VC_W; v++) begin
        pop_m[v] = (mc[v] != 0) && !i_b[v];
        if (pop_m[v]) begin
          sb_pop(v, e, ok);
          total++; if (!ok || head(v) !== e) begin bad++; $display("FAIL b2b_flit[%0d] vc%0d got=%h want=%h", cyc, v, head(v), e); end
        end
      end
      total++; if (o_vc_credit_gnt !== (REG ? prev_pop : pop_m)) begin
        bad++; $display("FAIL b2b_gnt[%0d] got=%b want=%b", cyc, o_vc_credit_gnt, REG ? prev_pop : pop_m);
      end
      r = $urandom_range(0, 3);
      tgt = '0;
      if (r == 1 || r == 2) begin
        if (mc[r-1] < DEPTH || pop_m[r-1]) tgt[r-1] = 1'b1;
      end
      f = {1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom)};
      i_packet = f; i_vc_target = tgt;
      for (int v = 0; v < VC_W; v++) begin
        if (tgt[v]) sb_push(v, f);
        mc[v] = mc[v] + int'(tgt[v]) - int'(pop_m[v]);
      end
      prev_pop = pop_m;
      tick;
    end
    i_vc_target = '0; i_b = 2'b00;
    guard = 0;
    while ((mc[0] != 0 || mc[1] != 0) && guard < 3 * DEPTH) begin
      for (int v = 0; v < VC_W; v++) begin
        if (mc[v] != 0) begin
          sb_pop(v, e, ok);
          total++; if (!ok || head(v) !== e) begin bad++; $display("FAIL b2b_drain vc%0d got=%h want=%h", v, head(v), e); end
          mc[v]--;
        end
      end
      tick;
      guard++;
    end
    total++; if (guard >= 3 * DEPTH || o_v !== 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++; $display("FAIL b2b_end got v=%b q0=%0d q1=%0d guard=%0d want empty", o_v, exp_q0.size(), exp_q1.size(), guard);
    end
    total++; if (o_err !== 2'b00) begin bad++; $display("FAIL b2b_err got=%b want=00", o_err); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_drain;
    test_full_same_edge;
    test_multi_hot_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/credit_bp_rx_nvc.md
Name: credit_bp_rx_nvc

Overview:
- Parametrised next-generation credit-based NoC receiver.
- Accepts flits from an upstream credit transmitter into VC_W independent per-VC FIFOs and presents each FIFO head to the switch routing logic over a per-VC valid/backpressure handshake.
- Returns one credit per popped flit.
- Additions over the first-generation receiver:
  - all DEPTH entries usable;
  - per-VC occupancy outputs;
  - sticky per-VC protocol-error flags with drop-on-error;
  - optional registered credit return.

Parameters:
- VC_W, 2, number of virtual channels (1..16)
- D_W, 32, payload data width
- A_W, 8, route address width
- DEPTH, 4, entries per VC FIFO (>=2, power of two not required; all DEPTH usable)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_vc_target  in  VC_W  one-hot push strobe from TX (all-zero = idle)
- i_packet  in  A_W+D_W+1  flit {last, addr, data}; last at bit A_W+D_W, addr at [D_W+A_W-1:D_W], data at [D_W-1:0]
- o_vc_credit_gnt  out  VC_W  per-VC credit return pulse to TX
- o_v  out  VC_W  per-VC head valid
- o_d  out  VC_W x (A_W+D_W+1)  per-VC head flit, same packing as i_packet
- i_b  in  VC_W  per-VC backpressure from switch (1 = hold)
- o_count  out  VC_W x CNT_W  per-VC occupancy
- o_err  out  VC_W  sticky per-VC protocol error
- i_err_clr  in  1  clears all o_err bits

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all FIFOs emptied, o_v=0, o_count=0, o_err=0, o_vc_credit_gnt=0.
  - o_d is don't-care but must be driven, not X-propagating from uninitialised storage in simulation.
- Reset mid-traffic: all in-flight contents discarded. TX is reset in the same cycle and restarts with DEPTH credits per VC.
- Push: i_vc_target[v]=1 at a rising edge writes i_packet into FIFO v.
  - Flit is visible at o_d[v] with o_v[v]=1 no earlier than the next cycle (1-cycle push-to-valid latency when the FIFO was empty).
- Pop: occurs on any edge where o_v[v]=1 and i_b[v]=0.
  - The next entry (if any) appears at o_d[v] after that edge.
  - The head stays stable while i_b[v]=1.
- Credit return (default, combinational): o_vc_credit_gnt[v] = o_v[v] & ~i_b[v]. Exactly one credit per pop.
- Simultaneous push and pop on the same VC: both take effect; count unchanged.
  - Legal when full (the slot is freed the same edge).
  - When empty, a push and pop cannot coincide because o_v=0.
- o_count[v] = entries held, 0..DEPTH; updated on the edge of each push/pop.
- Protocol errors (per VC, sticky until i_err_clr or reset):
  - Push to VC v while count==DEPTH and no same-edge pop: flit dropped, o_err[v] set, contents unchanged.
  - i_vc_target not one-hot and non-zero: flit dropped, o_err set for every asserted bit, no FIFO written.
- i_err_clr=1 clears o_err on that edge. An error detected on the same edge wins: the bit stays set.
- Pointer wrap: read/write indices wrap modulo DEPTH (explicit compare, not bit truncation, so non-power-of-two DEPTH works).
- No cross-VC coupling: backpressure or errors on one VC never stall another.

Optional Feature:
- Macro: CREDIT_BP_RX_NVC_REG_CREDIT_EN.
- Defined:
  - o_vc_credit_gnt is registered: the pulse asserts the cycle after the pop edge; reset value 0.
  - TX sees credits 1 cycle later; throughput is unchanged when TX credit pool >= 2.
- Undefined:
  - combinational grant as above, visible in the same cycle i_b[v] drops while o_v[v]=1.

Test Plan:
- Reset hold 2 cycles, release:
  - o_v=00, o_count={0,0}, o_err=00, o_vc_credit_gnt=00.
  - Idle with i_b=00 for 2 cycles: no change.
- Push 32'hDEADBEEF to VC0 with i_b=10:
  - next cycle o_v=01, o_d[0] data=DEADBEEF, gnt=01 (combinational build), count[0]=1.
  - Following cycle o_v=00, gnt=00.
- Fill VC1 with 4 flits (data=ii*456, addr/last truncated likewise) under i_b=11:
  - count[1]=4, gnt=00.
  - Fifth push: o_err=10, count[1] stays 4.
  - Drain with i_b=00: flits ii=0..3 appear in order, one per cycle, gnt=10 each cycle, then o_v=00.
- VC1 full and held, then same-edge push 32'h22222222 and pop:
  - count[1] stays 4, no error.
  - New flit emerges last in drain order.
- Push with i_vc_target=11:
  - o_err=11, o_v unchanged.
  - i_err_clr pulse: o_err=00.
  - rst_n=0 mid-stream with VC0 holding 3 flits: next cycle o_v=00, count=0.
- Rebuild with CREDIT_BP_RX_NVC_REG_CREDIT_EN defined and repeat the second scenario:
  - gnt=01 appears exactly one cycle after the pop edge, never coincident with it.
